// File: rtl/seg7_to_binary.sv
// Recovers a 4-digit decimal frame from a multiplexed, common-anode 7-segment display bus.
// Synchronizes the pins, waits for a stable single-digit selection, decodes it, and commits a full frame.
module seg7_to_binary #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sg7_g,
  input  logic        sg7_f,
  input  logic        sg7_e,
  input  logic        sg7_d,
  input  logic        sg7_c,
  input  logic        sg7_b,
  input  logic        sg7_a,
  input  logic [3:0]  dig_n,
  output logic [15:0] bcd,
  output logic [3:0]  err,
  output logic        frame_valid
);

  localparam int unsigned SAMPLE_W = 11;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DIGITS   = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 2);

  logic [SAMPLE_W-1:0] w_pins;
  logic [SAMPLE_W-1:0] r_sync1;
  logic [SAMPLE_W-1:0] r_sync2;
  logic [SAMPLE_W-1:0] r_prev;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [15:0]         r_shadow;
  logic [3:0]          r_shadow_err;
  logic [3:0]          r_seen;
  logic [3:0]          w_seen_next;
  logic [3:0]          w_sel;
  logic                w_sel_valid;
  logic                w_same;
  logic                w_capture;
  logic                w_commit;
  logic [3:0]          w_nib;
  logic                w_nib_err;

  assign w_pins = {dig_n, sg7_g, sg7_f, sg7_e, sg7_d, sg7_c, sg7_b, sg7_a};

  // Two-flop synchronizer plus one-cycle history; idle state is all-ones (nothing lit/selected).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_sel       = ~r_sync2[10:7];
  assign w_sel_valid = $onehot(w_sel);
  assign w_same      = (r_sync2 == r_prev);
  // Capture fires only on the transition into the saturated count, so once per stable run.
  assign w_capture   = w_sel_valid && w_same && (r_cnt == CNT_CAP);
  assign w_commit    = (r_seen == 4'hF);

  always_comb begin
    w_cnt_next = r_cnt;
    if (!w_sel_valid || !w_same) begin
      w_cnt_next = '0;
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // Segment pattern {g,f,e,d,c,b,a}, active-low.
  always_comb begin
    w_nib     = 4'hF;
    w_nib_err = 1'b0;
    case (r_sync2[6:0])
      7'b1000000: w_nib = 4'd0;
      7'b1111001: w_nib = 4'd1;
      7'b0100100: w_nib = 4'd2;
      7'b0110000: w_nib = 4'd3;
      7'b0011001: w_nib = 4'd4;
      7'b0010010: w_nib = 4'd5;
      7'b0000010: w_nib = 4'd6;
      7'b1111000: w_nib = 4'd7;
      7'b0000000: w_nib = 4'd8;
      7'b0011000: w_nib = 4'd9;
      default:    w_nib_err = 1'b1;
    endcase
  end

  // A capture in the commit cycle starts the next frame's seen set.
  always_comb begin
    w_seen_next = w_commit ? 4'b0000 : r_seen;
    if (w_capture) begin
      w_seen_next = w_seen_next | w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_seen       <= '0;
      r_shadow     <= '0;
      r_shadow_err <= '0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_seen <= w_seen_next;
      for (int i = 0; i < DIGITS; i++) begin
        if (w_capture && w_sel[i]) begin
          r_shadow[4*i +: 4] <= w_nib;
          r_shadow_err[i]    <= w_nib_err;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd         <= '0;
      err         <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= w_commit;
      if (w_commit) begin
        bcd <= r_shadow;
        err <= r_shadow_err;
      end
    end
  end

endmodule

// File: tb/tb_seg7_to_binary.sv
// Directed bench for seg7_to_binary: drives multiplexed digit scans and checks committed frames.
module tb_seg7_to_binary;

  logic        clk = 1'b0;
  logic        rst;
  logic        sg7_g, sg7_f, sg7_e, sg7_d, sg7_c, sg7_b, sg7_a;
  logic [3:0]  dig_n;
  logic [15:0] bcd;
  logic [3:0]  err;
  logic        frame_valid;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0011000;
  localparam logic [6:0] PB = 7'b1111111;

  int errors = 0;
  int checks = 0;
  int fv_count = 0;
  int base;
  logic [15:0] last_bcd = '0;
  logic [3:0]  last_err = '0;

  seg7_to_binary #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .sg7_g(sg7_g), .sg7_f(sg7_f), .sg7_e(sg7_e), .sg7_d(sg7_d),
    .sg7_c(sg7_c), .sg7_b(sg7_b), .sg7_a(sg7_a),
    .dig_n(dig_n), .bcd(bcd), .err(err), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  // Outputs are observed on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count = fv_count + 1;
      last_bcd = bcd;
      last_err = err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [3:0] d, input logic [6:0] p, input int n);
    dig_n = d;
    {sg7_g, sg7_f, sg7_e, sg7_d, sg7_c, sg7_b, sg7_a} = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold(4'b1111, PB, 3);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    dig_n = 4'b1111;
    {sg7_g, sg7_f, sg7_e, sg7_d, sg7_c, sg7_b, sg7_a} = PB;
    @(negedge clk);
    do_reset();
    check("reset_bcd", 32'(bcd), 32'h0000);
    check("reset_err", 32'(err), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);

    // Basic scan 1,2,3,4 on digits 0..3.
    base = fv_count;
    hold(4'b1110, P1, 10);
    hold(4'b1101, P2, 10);
    hold(4'b1011, P3, 10);
    hold(4'b0111, P4, 10);
    hold(4'b1111, PB, 10);
    check("scan_pulses", 32'(fv_count - base), 32'd1);
    check("scan_bcd", 32'(last_bcd), 32'h4321);
    check("scan_err", 32'(last_err), 32'h0);
    hold(4'b1111, PB, 20);
    check("hold_bcd", 32'(bcd), 32'h4321);

    // Blank digit 2 among eights.
    base = fv_count;
    hold(4'b1110, P8, 10);
    hold(4'b1101, P8, 10);
    hold(4'b1011, PB, 10);
    hold(4'b0111, P8, 10);
    hold(4'b1111, PB, 10);
    check("blank_pulses", 32'(fv_count - base), 32'd1);
    check("blank_bcd", 32'(last_bcd), 32'h8F88);
    check("blank_err", 32'(last_err), 32'h4);

    // Latency: final digit applied at cycle 0 captures at cycle 6, frame pulses at cycle 7.
    hold(4'b1101, P5, 10);
    hold(4'b1011, P6, 10);
    hold(4'b0111, P7, 10);
    base = fv_count;
    hold(4'b1110, P1, 6);
    check("lat_not_early", 32'(fv_count - base), 32'd0);
    @(negedge clk);
    check("lat_fv_cycle7", 32'(frame_valid), 32'h1);
    check("lat_bcd", 32'(bcd), 32'h7651);
    check("lat_err", 32'(err), 32'h0);
    repeat (30) @(negedge clk);
    check("lat_single_pulse", 32'(fv_count - base), 32'd1);
    // A repeat capture of digit 0 would complete a frame here.
    hold(4'b1101, P5, 10);
    hold(4'b1011, P6, 10);
    hold(4'b0111, P7, 10);
    hold(4'b1111, PB, 10);
    check("no_recapture", 32'(fv_count - base), 32'd1);

    // Glitching digit 0 every 3 cycles must never capture.
    do_reset();
    base = fv_count;
    for (int k = 0; k < 10; k++) begin
      hold(4'b1110, (k % 2 == 0) ? P1 : P2, 3);
    end
    hold(4'b1101, P9, 10);
    hold(4'b1011, P9, 10);
    hold(4'b0111, P9, 10);
    hold(4'b1111, PB, 10);
    check("glitch_no_frame", 32'(fv_count - base), 32'd0);
    hold(4'b1110, P0, 10);
    check("glitch_then_stable", 32'(fv_count - base), 32'd1);
    check("glitch_bcd", 32'(last_bcd), 32'h9990);

    // Invalid selections, then latest-capture-wins on digit 0.
    do_reset();
    base = fv_count;
    hold(4'b1100, P1, 20);
    hold(4'b1111, P1, 20);
    hold(4'b1110, P1, 10);
    hold(4'b1110, P2, 10);
    hold(4'b1101, P3, 10);
    hold(4'b1011, P3, 10);
    check("invalid_sel_no_frame", 32'(fv_count - base), 32'd0);
    hold(4'b0111, P3, 10);
    check("overwrite_pulses", 32'(fv_count - base), 32'd1);
    check("overwrite_bcd", 32'(last_bcd), 32'h3332);

    // Reset mid-frame discards digits 0 and 1.
    hold(4'b1110, P1, 10);
    hold(4'b1101, P2, 10);
    do_reset();
    check("midrst_bcd", 32'(bcd), 32'h0000);
    base = fv_count;
    hold(4'b1011, P9, 10);
    hold(4'b0111, P9, 10);
    hold(4'b1110, P9, 10);
    check("midrst_no_early", 32'(fv_count - base), 32'd0);
    hold(4'b1101, P9, 10);
    hold(4'b1111, PB, 10);
    check("midrst_pulses", 32'(fv_count - base), 32'd1);
    check("midrst_bcd9999", 32'(last_bcd), 32'h9999);
    check("midrst_err", 32'(last_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_to_binary.md
SEG7_TO_BINARY -- requirements
Module: seg7_to_binary

Interface
REQ-001 The parameter STABLE_CYCLES SHALL default to 4, range 2..255, and set the number of consecutive identical synchronized samples needed before a digit is captured.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 sg7_g, sg7_f, sg7_e, sg7_d, sg7_c, sg7_b, sg7_a  input  1 each  segment lines from a multiplexed common-anode display, active-low (0 = lit).
REQ-005 dig_n  input  4  digit enables, active-low; dig_n[i]=0 selects digit i (0 = least significant).
REQ-006 bcd  output  16  decoded frame; bcd[4i+3:4i] holds the value of digit i.
REQ-007 err  output  4  err[i]=1 when digit i held an undecodable pattern in the last frame.
REQ-008 frame_valid  output  1  one-cycle pulse when bcd and err update.

Function
REQ-009 The block SHALL pass all 11 input bits through a two-flop synchronizer before any other use.
REQ-010 A synchronized sample SHALL be a valid selection only when exactly one dig_n bit is 0.
REQ-011 When the selection is invalid (all bits 1 or more than one bit 0), the stability counter SHALL be cleared and no capture SHALL occur.
REQ-012 The stability counter SHALL clear whenever the synchronized 11-bit sample differs from the previous cycle's sample.
REQ-013 Otherwise the counter SHALL increment, saturating at STABLE_CYCLES-1.
REQ-014 Capture SHALL occur exactly once per stable run, on the cycle the counter reaches STABLE_CYCLES-1.
REQ-015 A further capture SHALL require the sample to change and re-stabilize.
REQ-016 Pin-to-capture latency SHALL be 2+STABLE_CYCLES clock cycles for a change held steady.
REQ-017 Decode SHALL use these patterns, written as {g,f,e,d,c,b,a}:
  - 1000000 -> 0
  - 1111001 -> 1
  - 0100100 -> 2
  - 0110000 -> 3
  - 0011001 -> 4
  - 0010010 -> 5
  - 0000010 -> 6
  - 1111000 -> 7
  - 0000000 -> 8
  - 0011000 -> 9
REQ-018 Any other pattern, including blank 1111111, SHALL decode to nibble 4'hF with the error flag set.
REQ-019 A capture SHALL write the selected digit's shadow nibble and shadow error flag, and SHALL set seen[i].
REQ-020 A repeated capture of the same digit within a frame SHALL overwrite the shadow entry, so the latest capture wins.
REQ-021 When seen becomes 4'b1111 (including the capture of that cycle), the next cycle SHALL:
  - copy the shadow values to bcd and err;
  - assert frame_valid for exactly one cycle;
  - clear seen.
REQ-022 A capture arriving in the same cycle as a frame commit SHALL count toward the next frame.
REQ-023 bcd and err SHALL hold their values between commits.
REQ-024 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 While rst=1, the following SHALL reset to 0:
  - bcd = 16'h0000, err = 4'b0000, frame_valid = 0;
  - seen, shadow registers and the stability counter.
REQ-026 While rst=1, the synchronizer and previous-sample registers SHALL reset to all-ones (inactive).
REQ-027 Reset asserted mid-frame SHALL discard all partial captures, and no frame_valid SHALL follow reset until four new captures complete.

Verification
REQ-028 Scan digits 0..3 showing 1,2,3,4 (0 on dig_n[0]), each held 10 cycles, STABLE_CYCLES=4 -> one frame_valid pulse with bcd=16'h4321 and err=4'b0000.
REQ-029 dig_n=4'b1110 with pattern 1111001 applied at cycle 0 and held -> capture at cycle 6, and no second capture while the inputs stay unchanged.
REQ-030 Digit 2 shows 1111111 during a full scan with the other digits showing 8 -> bcd=16'h8F88 and err=4'b0100.
REQ-031 Pattern glitches every 3 cycles with STABLE_CYCLES=4 -> no capture and no frame_valid.
REQ-032 dig_n=4'b1100 held 20 cycles -> no capture; dig_n=4'b1111 held 20 cycles -> no capture.
REQ-033 rst pulsed after digits 0 and 1 are captured, then a full scan of 9,9,9,9 -> exactly one frame_valid with bcd=16'h9999, and no pulse before the fourth post-reset capture.
